// File: rtl/key_gen_pkg.sv
// Shared types and default widths for the key generation sequencer.
package key_gen_pkg;

    localparam int unsigned KG_KEY_W = 32;
    localparam int unsigned KG_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        COMBINE = 3'd2,
        PUSH    = 3'd3,
        DONE    = 3'd4
    } kg_state_e;

    typedef struct packed {
        logic [KG_KEY_W-1:0] k1;
        logic [KG_KEY_W-1:0] k2;
    } key_pair_t;

endpackage

// File: rtl/key_pair_fifo.sv
// Synchronous FIFO of combined key pairs; DEPTH must be a power of two.
module key_pair_fifo
    import key_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  key_pair_t wdata,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output key_pair_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    key_pair_t          mem_q [DEPTH];
    key_pair_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               do_push_c;
    logic               do_pop_c;

    assign full      = (occ_q == OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign do_push_c = push && !full;
    assign do_pop_c  = pop && !empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push_c && !do_pop_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Storage is cleared on reset so the head reads zero after a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/key_gen_sequencer.sv
// Fetches log and chaos pairs, XOR-combines them and queues the key pairs.
// Optional feature macro: KEYGEN_WEAK_KEY_CHECK_EN drops pairs with a zero half.
module key_gen_sequencer
    import key_gen_pkg::*;
#(
    parameter int unsigned KEY_W      = KG_KEY_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = KG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_keys,
    input  logic             log_valid,
    output logic             log_ready,
    input  logic [KEY_W-1:0] log_key1,
    input  logic [KEY_W-1:0] log_key2,
    input  logic             chaos_valid,
    output logic             chaos_ready,
    input  logic [KEY_W-1:0] chaos_x,
    input  logic [KEY_W-1:0] chaos_y,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_W-1:0] final_key1,
    output logic [KEY_W-1:0] final_key2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] reject_cnt
);

    kg_state_e        state_q, state_d;
    logic [CNT_W-1:0] num_keys_q, num_keys_d;
    logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
    logic [CNT_W-1:0] reject_cnt_q, reject_cnt_d;
    logic             log_cap_q, log_cap_d;
    logic             chaos_cap_q, chaos_cap_d;
    logic [KEY_W-1:0] log_key1_h_q, log_key1_h_d;
    logic [KEY_W-1:0] log_key2_h_q, log_key2_h_d;
    logic [KEY_W-1:0] chaos_x_h_q, chaos_x_h_d;
    logic [KEY_W-1:0] chaos_y_h_q, chaos_y_h_d;
    logic [KEY_W-1:0] k1_q, k1_d;
    logic [KEY_W-1:0] k2_q, k2_d;

    logic             log_hs_c;
    logic             chaos_hs_c;
    logic             weak_c;
    logic             last_c;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    key_pair_t        fifo_wdata;
    key_pair_t        fifo_head;

    assign log_hs_c   = log_valid && log_ready;
    assign chaos_hs_c = chaos_valid && chaos_ready;
    assign last_c     = ((gen_cnt_q + CNT_W'(1)) == num_keys_q);
`ifdef KEYGEN_WEAK_KEY_CHECK_EN
    assign weak_c     = (k1_q == '0) || (k2_q == '0);
`else
    assign weak_c     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_keys == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if ((log_cap_q || log_hs_c) && (chaos_cap_q || chaos_hs_c)) begin
                    state_d = COMBINE;
                end
            end
            COMBINE: state_d = PUSH;
            PUSH: begin
                if (weak_c) begin
                    state_d = FETCH;
                end else if (!fifo_full) begin
                    state_d = last_c ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        log_ready   = 1'b0;
        chaos_ready = 1'b0;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        fifo_push   = 1'b0;
        if (state_q == FETCH) begin
            log_ready   = !log_cap_q;
            chaos_ready = !chaos_cap_q;
        end
        if (state_q == PUSH) begin
            fifo_push = !fifo_full && !weak_c;
        end
    end

    // Batch counters, capture registers and combined key datapath.
    always_comb begin
        num_keys_d   = num_keys_q;
        gen_cnt_d    = gen_cnt_q;
        reject_cnt_d = reject_cnt_q;
        log_cap_d    = log_cap_q;
        chaos_cap_d  = chaos_cap_q;
        log_key1_h_d = log_key1_h_q;
        log_key2_h_d = log_key2_h_q;
        chaos_x_h_d  = chaos_x_h_q;
        chaos_y_h_d  = chaos_y_h_q;
        k1_d         = k1_q;
        k2_d         = k2_q;

        if ((state_q == IDLE) && start) begin
            num_keys_d   = num_keys;
            gen_cnt_d    = '0;
            reject_cnt_d = '0;
        end
        if (log_hs_c) begin
            log_key1_h_d = log_key1;
            log_key2_h_d = log_key2;
            log_cap_d    = 1'b1;
        end
        if (chaos_hs_c) begin
            chaos_x_h_d = chaos_x;
            chaos_y_h_d = chaos_y;
            chaos_cap_d = 1'b1;
        end
        if (state_q == COMBINE) begin
            k1_d        = log_key1_h_q ^ chaos_x_h_q;
            k2_d        = log_key2_h_q ^ chaos_y_h_q;
            log_cap_d   = 1'b0;
            chaos_cap_d = 1'b0;
        end
        if (fifo_push) begin
            gen_cnt_d = gen_cnt_q + CNT_W'(1);
        end
`ifdef KEYGEN_WEAK_KEY_CHECK_EN
        if ((state_q == PUSH) && weak_c && (reject_cnt_q != '1)) begin
            reject_cnt_d = reject_cnt_q + CNT_W'(1);
        end
`endif
    end

    // Datapath registers; reset discards any held inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_keys_q   <= '0;
            gen_cnt_q    <= '0;
            reject_cnt_q <= '0;
            log_cap_q    <= 1'b0;
            chaos_cap_q  <= 1'b0;
            log_key1_h_q <= '0;
            log_key2_h_q <= '0;
            chaos_x_h_q  <= '0;
            chaos_y_h_q  <= '0;
            k1_q         <= '0;
            k2_q         <= '0;
        end else begin
            num_keys_q   <= num_keys_d;
            gen_cnt_q    <= gen_cnt_d;
            reject_cnt_q <= reject_cnt_d;
            log_cap_q    <= log_cap_d;
            chaos_cap_q  <= chaos_cap_d;
            log_key1_h_q <= log_key1_h_d;
            log_key2_h_q <= log_key2_h_d;
            chaos_x_h_q  <= chaos_x_h_d;
            chaos_y_h_q  <= chaos_y_h_d;
            k1_q         <= k1_d;
            k2_q         <= k2_d;
        end
    end

    assign fifo_wdata.k1 = KG_KEY_W'(k1_q);
    assign fifo_wdata.k2 = KG_KEY_W'(k2_q);

    key_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (key_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign key_valid  = !fifo_empty;
    assign final_key1 = KEY_W'(fifo_head.k1);
    assign final_key2 = KEY_W'(fifo_head.k2);
    assign reject_cnt = reject_cnt_q;

endmodule
